cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Common data bus (CDB) producer for the out-of-order core. It collects completed results from the functional units / reservation stations, buffers them per unit, and picks one per cycle with a round-robin arbiter. The winner is driven as a registered broadcast (valid, value, rs tag). The register file and the reservation stations consume this broadcast to clear virtual (renamed) entries.

Parameters:
DATA_WIDTH, 64, width of the result value.
NUM_UNITS, 4, number of requesting functional units; legal range 2..8.
FIFO_DEPTH, 2, entries per unit result buffer; power of two, at least 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
flush_i  input  1  pipeline flush (mispredict); discards all buffered results.
req_valid_i[NUM_UNITS]  input  1 each  unit i has a completed result.
req_value_i[NUM_UNITS]  input  DATA_WIDTH each  result value of unit i.
req_rs_i[NUM_UNITS]  input  e_functional_unit each  rs tag of the result from unit i.
req_ready_o[NUM_UNITS]  output  1 each  unit i buffer can accept this cycle.
bcast_valid_o  output  1  broadcast valid this cycle.
bcast_value_o  output  DATA_WIDTH  broadcast value.
bcast_rs_o  output  e_functional_unit  broadcast rs tag.

Behaviour:
- Reset (rst=1 at posedge): all FIFOs empty, rr_ptr=0, bcast_valid_o=0, bcast_value_o=0, bcast_rs_o=all-zero encoding. rst has priority over flush_i and all requests.
- Handshake: a result is accepted when req_valid_i[i] && req_ready_o[i]. req_ready_o[i] = (count_i != FIFO_DEPTH) && !flush_i. Ready does not depend on a same-cycle pop, so a full FIFO rejects pushes even in a cycle where it pops. An accepted entry is written at the FIFO tail.
- Arbitration, every cycle: candidates are the units with a non-empty FIFO. The winner is the first candidate at or after rr_ptr in circular index order.
  - Winner found: pop its head; on the next posedge register bcast_valid_o=1 and load value and rs from that head; set rr_ptr to (winner+1) mod NUM_UNITS.
  - No candidate: bcast_valid_o=0 next cycle; value and rs hold their previous values; rr_ptr unchanged.
- Latency: a push in cycle N makes the entry eligible in N+1 at the earliest, so bcast_valid_o is visible in N+2.
- At most one broadcast per cycle. Each accepted result is broadcast exactly once, in per-unit FIFO order.
- A push and a pop on the same FIFO in the same cycle are legal; count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Flush (flush_i=1, rst=0):
  - All FIFOs are emptied and rr_ptr=0 at the posedge.
  - bcast_valid_o=0 in the following cycle.
  - No push is accepted in the flush cycle.
  - An entry arbitrated in the flush cycle is dropped, not broadcast.
- Fairness: with all units continuously non-empty, each unit wins exactly once every NUM_UNITS cycles.

Optional Feature:
Macro CDB_BYPASS_EN.
- Defined: if unit i's FIFO is empty and req_valid_i[i] is high and accepted, the incoming request is a candidate in the same cycle. If it wins, it is broadcast at N+1 without being written to the FIFO; if it loses, it is pushed as normal. Ordering is preserved because bypass applies only to an empty FIFO.
- Not defined: latency is fixed at 2 cycles as specified above.

Test Plan:
- Reset, then idle: bcast_valid_o=0, all req_ready_o=1, bcast_value_o=0 for 5 cycles.
- Single push: unit 2 sends value 0xDEAD, rs=tag2, in cycle 10 → bcast_valid_o=1 with 0xDEAD/tag2 in cycle 12 only (cycle 11 with CDB_BYPASS_EN).
- Round-robin: units 0..3 each push 2 results in the same cycle → 8 consecutive broadcasts in unit order 0,1,2,3,0,1,2,3, with per-unit order preserved.
- Backpressure: unit 1 pushes 3 back-to-back while units 0, 2 and 3 hold the bus busy → req_ready_o[1]=0 once count=2; no loss or duplication; all 3 values eventually broadcast in order.
- Flush with 5 entries buffered across units → no further bcast_valid_o after the flush posedge; next push to unit 3 is broadcast at the normal latency, and rr_ptr restarts at 0.
- Reset asserted mid-stream with full FIFOs → next cycle bcast_valid_o=0 and all req_ready_o=1; no stale value is ever broadcast afterwards.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- common data bus producer for the out-of-order core.
//
// Each functional unit pushes completed results into its own small FIFO.
// Every cycle a round-robin arbiter picks one non-empty FIFO, pops its head
// and drives it as a registered broadcast (valid, value, rs tag) that the
// register file and reservation stations use to clear renamed entries.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset (priority over everything)
//   flush_i        pipeline flush: drops all buffered and in-flight results
//   req_valid_i    per unit: a completed result is presented
//   req_value_i    per unit: result value
//   req_rs_i       per unit: rs tag of the result
//   req_ready_o    per unit: buffer can accept this cycle
//   bcast_valid_o  broadcast valid
//   bcast_value_o  broadcast value
//   bcast_rs_o     broadcast rs tag
//
// Optional build macro: CDB_BYPASS_EN
//   When defined, a request arriving at an empty FIFO competes in the same
//   cycle and, if it wins, is broadcast one cycle later without being stored.
//   When undefined, push-to-broadcast latency is always two cycles.

package cdb_pkg;
    typedef enum logic [2:0] {
        RS_NONE   = 3'd0,
        RS_ALU0   = 3'd1,
        RS_ALU1   = 3'd2,
        RS_MUL    = 3'd3,
        RS_DIV    = 3'd4,
        RS_LOAD   = 3'd5,
        RS_STORE  = 3'd6,
        RS_BRANCH = 3'd7
    } e_functional_unit;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [NUM_UNITS-1:0]  req_valid_i,
    input  logic [DATA_WIDTH-1:0] req_value_i [NUM_UNITS],
    input  e_functional_unit      req_rs_i    [NUM_UNITS],
    output logic [NUM_UNITS-1:0]  req_ready_o,
    output logic                  bcast_valid_o,
    output logic [DATA_WIDTH-1:0] bcast_value_o,
    output e_functional_unit      bcast_rs_o
);
    localparam int unsigned UW = $clog2(NUM_UNITS);
    localparam int unsigned SW = UW + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [UW-1:0] LAST = UW'(NUM_UNITS - 1);

    logic [DATA_WIDTH-1:0] mem_value [NUM_UNITS][FIFO_DEPTH];
    e_functional_unit      mem_rs    [NUM_UNITS][FIFO_DEPTH];
    logic [PW-1:0]         head      [NUM_UNITS];
    logic [PW-1:0]         tail      [NUM_UNITS];
    logic [CW-1:0]         count     [NUM_UNITS];
    logic [UW-1:0]         rr_ptr;

    logic [NUM_UNITS-1:0]  push;
    logic [NUM_UNITS-1:0]  cand;
    logic [NUM_UNITS-1:0]  pop;
    logic [NUM_UNITS-1:0]  store;
    logic                  found;
    logic                  bypass;
    logic [UW-1:0]         winner;
    logic [UW-1:0]         idx;
    logic [SW-1:0]         sum;
    logic [DATA_WIDTH-1:0] sel_value;
    e_functional_unit      sel_rs;

    // Ready looks only at the registered count, never at a same-cycle pop.
    always_comb begin
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            req_ready_o[i] = (count[i] != FULL) && !flush_i;
            push[i]        = req_valid_i[i] && req_ready_o[i];
`ifdef CDB_BYPASS_EN
            cand[i]        = (count[i] != '0) || push[i];
`else
            cand[i]        = (count[i] != '0);
`endif
        end
    end

    always_comb begin
        found     = 1'b0;
        winner    = '0;
        idx       = '0;
        sum       = '0;
        bypass    = 1'b0;
        // Scan circularly starting at rr_ptr; first candidate wins.
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NUM_UNITS)) begin
                sum = sum - SW'(NUM_UNITS);
            end
            idx = sum[UW-1:0];
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        sel_value = mem_value[winner][head[winner]];
        sel_rs    = mem_rs[winner][head[winner]];
`ifdef CDB_BYPASS_EN
        // An empty FIFO can only be a candidate through its incoming request.
        if (count[winner] == '0) begin
            bypass    = found;
            sel_value = req_value_i[winner];
            sel_rs    = req_rs_i[winner];
        end
`endif
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            pop[i]   = found && (winner == UW'(i)) && !bypass;
            store[i] = push[i] && !(bypass && (winner == UW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr        <= '0;
            bcast_valid_o <= 1'b0;
            bcast_value_o <= '0;
            bcast_rs_o    <= RS_NONE;
        end else if (flush_i) begin
            // The entry arbitrated this cycle is dropped; value/rs hold.
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr        <= '0;
            bcast_valid_o <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                if (store[i]) begin
                    mem_value[i][tail[i]] <= req_value_i[i];
                    mem_rs[i][tail[i]]    <= req_rs_i[i];
                    tail[i]               <= tail[i] + PW'(1);
                end
                if (pop[i]) begin
                    head[i] <= head[i] + PW'(1);
                end
                count[i] <= count[i] + CW'(store[i]) - CW'(pop[i]);
            end
            bcast_valid_o <= found;
            if (found) begin
                bcast_value_o <= sel_value;
                bcast_rs_o    <= sel_rs;
                rr_ptr        <= (winner == LAST) ? '0 : winner + UW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter -- self-checking bench for cdb_arbiter (4 units, depth 2).
// Expected broadcasts go into a scoreboard queue when stimulus is driven and
// are popped by a negedge monitor whenever bcast_valid_o is high.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned NU = 4;
    localparam int unsigned FD = 2;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [NU-1:0]     req_valid = '0;
    logic [DW-1:0]     req_value [NU];
    e_functional_unit  req_rs [NU];
    logic [NU-1:0]     req_ready;
    logic              bcast_valid;
    logic [DW-1:0]     bcast_value;
    e_functional_unit  bcast_rs;

    cdb_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_UNITS  (NU),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_value_i   (req_value),
        .req_rs_i      (req_rs),
        .req_ready_o   (req_ready),
        .bcast_valid_o (bcast_valid),
        .bcast_value_o (bcast_value),
        .bcast_rs_o    (bcast_rs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int               at;      // expected broadcast cycle, -1 = order only
        logic [DW-1:0]    value;
        e_functional_unit rs;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          fl;
        logic [NU-1:0] valid;
        logic [DW-1:0] value;
        logic [NU-1:0] exp_rdy;
        logic          exp_bv;
        logic          chk_val;
    } vec_t;

    function automatic e_functional_unit tag(input int u);
        return e_functional_unit'(3'(u + 1));
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic expect_bc(input int at, input logic [DW-1:0] v, input int u);
        exp_t e;
        e.at    = at;
        e.value = v;
        e.rs    = tag(u);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        req_valid = '0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        check("drain_empty", DW'(sb.size()), DW'(0));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bcast_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_bcast", DW'(bcast_value), DW'(0));
                if (bcast_value === '0) begin
                    check("unexpected_bcast_valid", DW'(1), DW'(0));
                end
            end else begin
                e = sb.pop_front();
                check("bcast_value", bcast_value, e.value);
                check("bcast_rs", DW'(bcast_rs), DW'(e.rs));
                if (e.at >= 0) check("bcast_cycle", DW'(cyc), DW'(e.at));
            end
        end else if (sb.size() != 0 && sb[0].at >= 0 && sb[0].at <= cyc) begin
            check("missed_bcast", DW'(0), DW'(1));
            void'(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        int   c;
        int   waited;

        for (int u = 0; u < NU; u++) begin
            req_value[u] = '0;
            req_rs[u]    = RS_NONE;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset/idle, flush rejecting pushes, then one push with its latency.
        for (int r = 0; r < 5; r++)
            tbl[r] = '{fl: 1'b0, valid: 4'h0, value: 64'h0, exp_rdy: 4'hF, exp_bv: 1'b0, chk_val: 1'b1};
        tbl[5]  = '{fl: 1'b1, valid: 4'hF, value: 64'h5555, exp_rdy: 4'h0, exp_bv: 1'b0, chk_val: 1'b0};
        tbl[6]  = '{fl: 1'b0, valid: 4'h0, value: 64'h0, exp_rdy: 4'hF, exp_bv: 1'b0, chk_val: 1'b0};
        tbl[7]  = '{fl: 1'b0, valid: 4'h1, value: 64'h1111, exp_rdy: 4'hF, exp_bv: 1'b0, chk_val: 1'b0};
        tbl[8]  = '{fl: 1'b0, valid: 4'h0, value: 64'h0, exp_rdy: 4'hF, exp_bv: (LAT == 1), chk_val: 1'b0};
        tbl[9]  = '{fl: 1'b0, valid: 4'h0, value: 64'h0, exp_rdy: 4'hF, exp_bv: (LAT == 2), chk_val: 1'b0};
        tbl[10] = '{fl: 1'b0, valid: 4'h0, value: 64'h0, exp_rdy: 4'hF, exp_bv: 1'b0, chk_val: 1'b0};

        for (int r = 0; r < 11; r++) begin
            tick();
            flush     = tbl[r].fl;
            req_valid = tbl[r].valid;
            for (int u = 0; u < NU; u++) begin
                if (tbl[r].valid[u]) begin
                    req_value[u] = tbl[r].value;
                    req_rs[u]    = tag(u);
                    if (!tbl[r].fl && tbl[r].exp_rdy[u]) expect_bc(cyc + LAT, tbl[r].value, u);
                end
            end
            @(negedge clk);
            check($sformatf("tbl%0d_ready", r), DW'(req_ready), DW'(tbl[r].exp_rdy));
            check($sformatf("tbl%0d_bvalid", r), DW'(bcast_valid), DW'(tbl[r].exp_bv));
            if (tbl[r].chk_val) begin
                check($sformatf("tbl%0d_bvalue", r), bcast_value, DW'(0));
                check($sformatf("tbl%0d_brs", r), DW'(bcast_rs), DW'(0));
            end
        end

        // Single push from unit 2: broadcast exactly LAT cycles later, once.
        tick();
        req_valid    = 4'b0100;
        req_value[2] = 64'hDEAD;
        req_rs[2]    = tag(2);
        expect_bc(cyc + LAT, 64'hDEAD, 2);
        tick();
        idle();
        repeat (5) tick();
        check("single_drained", DW'(sb.size()), DW'(0));

        // Round robin: two results per unit on back-to-back cycles.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        c = cyc;
        for (int k = 0; k < NU; k++) expect_bc(c + LAT + k, 64'h100 + DW'(k), k);
        for (int k = 0; k < NU; k++) expect_bc(c + LAT + NU + k, 64'h200 + DW'(k), k);
        req_valid = 4'hF;
        for (int u = 0; u < NU; u++) begin
            req_value[u] = 64'h100 + DW'(u);
            req_rs[u]    = tag(u);
        end
        @(negedge clk);
        check("rr_ready_a", DW'(req_ready), DW'(4'hF));
        tick();
        for (int u = 0; u < NU; u++) req_value[u] = 64'h200 + DW'(u);
        @(negedge clk);
        check("rr_ready_b", DW'(req_ready), DW'(4'hF));
        tick();
        idle();
        drain(20);

        // Backpressure on unit 1 while the other units keep the bus busy.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_bc(-1, 64'h300, 0);
        expect_bc(-1, 64'h311, 1);
        expect_bc(-1, 64'h320, 2);
        expect_bc(-1, 64'h330, 3);
        expect_bc(-1, 64'h301, 0);
        expect_bc(-1, 64'h312, 1);
        expect_bc(-1, 64'h321, 2);
        expect_bc(-1, 64'h331, 3);
        expect_bc(-1, 64'h313, 1);
        req_valid = 4'hF;
        req_value[0] = 64'h300; req_value[1] = 64'h311;
        req_value[2] = 64'h320; req_value[3] = 64'h330;
        for (int u = 0; u < NU; u++) req_rs[u] = tag(u);
        @(negedge clk);
        check("bp_ready_c0", DW'(req_ready), DW'(4'hF));
        tick();
        req_value[0] = 64'h301; req_value[1] = 64'h312;
        req_value[2] = 64'h321; req_value[3] = 64'h331;
        @(negedge clk);
        check("bp_ready_c1", DW'(req_ready[1]), DW'(1));
        tick();
        req_valid    = 4'b0010;
        req_value[1] = 64'h313;
        @(negedge clk);
        check("bp_ready_full", DW'(req_ready[1]), (LAT == 2) ? DW'(0) : DW'(1));
        waited = 0;
        while (req_ready[1] !== 1'b1 && waited < 8) begin
            tick();
            @(negedge clk);
            waited++;
        end
        check("bp_accept", DW'(req_ready[1]), DW'(1));
        tick();
        idle();
        drain(30);

        // Flush with five results buffered across units.
        c = cyc;
        req_valid = 4'hF;
        for (int u = 0; u < NU; u++) req_value[u] = 64'h400 + DW'(u);
        expect_bc(c + LAT, 64'h402, 2);
`ifdef CDB_BYPASS_EN
        expect_bc(c + 2, 64'h403, 3);
`endif
        tick();
        req_valid    = 4'b0011;
        req_value[0] = 64'h410;
        req_value[1] = 64'h411;
        tick();
        flush        = 1'b1;
        req_valid    = 4'b1000;
        req_value[3] = 64'h4FF;
        @(negedge clk);
        check("flush_ready", DW'(req_ready), DW'(0));
        tick();
        idle();
        @(negedge clk);
        check("flush_bvalid", DW'(bcast_valid), DW'(0));
        check("flush_ready_after", DW'(req_ready), DW'(4'hF));
        repeat (5) tick();
        req_valid    = 4'b1000;
        req_value[3] = 64'h4AA;
        expect_bc(cyc + LAT, 64'h4AA, 3);
        tick();
        idle();
        drain(10);

        // Reset asserted mid-stream with the FIFOs filling up.
        c = cyc;
        req_valid = 4'hF;
        for (int u = 0; u < NU; u++) req_value[u] = 64'h500 + DW'(u);
        expect_bc(c + LAT, 64'h500, 0);
`ifdef CDB_BYPASS_EN
        expect_bc(c + 2, 64'h501, 1);
`endif
        tick();
        for (int u = 0; u < NU; u++) req_value[u] = 64'h510 + DW'(u);
        tick();
        for (int u = 0; u < NU; u++) req_value[u] = 64'h520 + DW'(u);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rst_bvalid", DW'(bcast_valid), DW'(0));
        check("rst_ready", DW'(req_ready), DW'(4'hF));
        check("rst_bvalue", bcast_value, DW'(0));
        check("rst_brs", DW'(bcast_rs), DW'(0));
        repeat (8) tick();

        check("final_queue", DW'(sb.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
